// File: rtl/irrigation_cycle_scheduler.sv
// Initiator side of the greenhouse sequencer handshake.
// Programs stage durations, raises seq_enable, waits for seq_done, releases enable
// for one cycle, optionally rests, then repeats. Faults on zero-duration config,
// a missing seq_done (watchdog) and simultaneous irrigation/ventilation.
module irrigation_cycle_scheduler #(
    parameter int unsigned MARGIN = 4,
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_d1,
    input  logic [7:0]        cfg_d2,
    input  logic [7:0]        cfg_d3,
    input  logic [7:0]        cfg_rest,
    input  logic [3:0]        cfg_repeat,
    input  logic              seq_done,
    input  logic              seq_irrigation,
    input  logic              seq_ventilation,
    output logic              seq_enable,
    output logic [7:0]        seq_d1,
    output logic [7:0]        seq_d2,
    output logic [7:0]        seq_d3,
    output logic              busy,
    output logic [3:0]        cycles_done,
    output logic              sched_done,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [TICK_W-1:0] irr_ticks,
    output logic [TICK_W-1:0] vent_ticks
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StRelease,
        StRest,
        StFault
    } state_e;

    localparam logic [1:0] FcNone    = 2'b00;
    localparam logic [1:0] FcCfg     = 2'b01;
    localparam logic [1:0] FcTimeout = 2'b10;
    localparam logic [1:0] FcProto   = 2'b11;

    localparam logic [TICK_W-1:0] TickMax = {TICK_W{1'b1}};

    state_e      state_q, state_d;
    logic        seq_enable_q;
    logic [7:0]  d1_q, d2_q, d3_q;
    logic [7:0]  rest_q;
    logic [3:0]  repeat_q;
    logic [3:0]  cycles_done_q, cycles_done_d;
    logic        sched_done_q, sched_done_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [9:0]  wd_q, wd_d;
    logic [7:0]  rest_cnt_q, rest_cnt_d;
    logic [TICK_W-1:0] irr_q, vent_q;

    logic        load_cfg;
    logic        overlap;
    logic        cfg_zero;
    logic        counting;
    logic [9:0]  budget;
    logic [9:0]  wd_inc;
    logic        timeout;

    // Watchdog budget: sum of latched durations plus slack; 10 bits cannot overflow.
    always_comb begin
        budget = {2'b00, d1_q} + {2'b00, d2_q} + {2'b00, d3_q} + 10'(MARGIN);
    end

    // wd_q holds RUN cycles already completed; wd_inc includes the current one,
    // so the timeout fires in the budget-th RUN cycle.
    always_comb begin
        wd_inc   = wd_q + 10'd1;
        timeout  = (wd_inc == budget);
        overlap  = seq_irrigation & seq_ventilation;
        cfg_zero = (cfg_d1 == 8'd0) | (cfg_d2 == 8'd0) | (cfg_d3 == 8'd0);
        counting = (state_q == StRun) | (state_q == StRelease) | (state_q == StRest);
    end

    // Next-state logic; per-state priority is abort, overlap fault, done, watchdog.
    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        cycles_done_d = cycles_done_q;
        sched_done_d  = 1'b0;
        wd_d          = wd_q;
        rest_cnt_d    = rest_cnt_q;
        load_cfg      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (cfg_zero) begin
                        state_d      = StFault;
                        fault_code_d = FcCfg;
                    end else begin
                        load_cfg      = 1'b1;
                        cycles_done_d = 4'd0;
                        wd_d          = 10'd0;
                        state_d       = StRun;
                    end
                end
            end

            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (overlap) begin
                    state_d      = StFault;
                    fault_code_d = FcProto;
                end else if (seq_done) begin
                    cycles_done_d = cycles_done_q + 4'd1;
                    state_d       = StRelease;
                end else if (timeout) begin
                    state_d      = StFault;
                    fault_code_d = FcTimeout;
                end else begin
                    wd_d = wd_inc;
                end
            end

            StRelease: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (overlap) begin
                    state_d      = StFault;
                    fault_code_d = FcProto;
                end else if ((repeat_q != 4'd0) && (cycles_done_q == repeat_q)) begin
                    state_d      = StIdle;
                    sched_done_d = 1'b1;
                end else if (rest_q == 8'd0) begin
                    state_d = StRun;
                    wd_d    = 10'd0;
                end else begin
                    state_d    = StRest;
                    rest_cnt_d = 8'd0;
                end
            end

            StRest: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (overlap) begin
                    state_d      = StFault;
                    fault_code_d = FcProto;
                end else if ((rest_cnt_q + 8'd1) == rest_q) begin
                    state_d = StRun;
                    wd_d    = 10'd0;
                end else begin
                    rest_cnt_d = rest_cnt_q + 8'd1;
                end
            end

            StFault: begin
                // Acknowledge only: return to IDLE without launching.
                if (start) begin
                    state_d      = StIdle;
                    fault_code_d = FcNone;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, handshake and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            seq_enable_q  <= 1'b0;
            cycles_done_q <= 4'd0;
            sched_done_q  <= 1'b0;
            fault_code_q  <= FcNone;
            wd_q          <= 10'd0;
            rest_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            seq_enable_q  <= (state_d == StRun);
            cycles_done_q <= cycles_done_d;
            sched_done_q  <= sched_done_d;
            fault_code_q  <= fault_code_d;
            wd_q          <= wd_d;
            rest_cnt_q    <= rest_cnt_d;
        end
    end

    // Shadow configuration, loaded only on an accepted launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_q     <= 8'd0;
            d2_q     <= 8'd0;
            d3_q     <= 8'd0;
            rest_q   <= 8'd0;
            repeat_q <= 4'd0;
        end else if (load_cfg) begin
            d1_q     <= cfg_d1;
            d2_q     <= cfg_d2;
            d3_q     <= cfg_d3;
            rest_q   <= cfg_rest;
            repeat_q <= cfg_repeat;
        end
    end

    // Saturating activity counters, cleared on an accepted launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_q  <= '0;
            vent_q <= '0;
        end else if (load_cfg) begin
            irr_q  <= '0;
            vent_q <= '0;
        end else if (counting) begin
            if (seq_irrigation && (irr_q != TickMax)) begin
                irr_q <= irr_q + 1'b1;
            end
            if (seq_ventilation && (vent_q != TickMax)) begin
                vent_q <= vent_q + 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        seq_enable  = seq_enable_q;
        seq_d1      = d1_q;
        seq_d2      = d2_q;
        seq_d3      = d3_q;
        busy        = counting;
        cycles_done = cycles_done_q;
        sched_done  = sched_done_q;
        fault       = (state_q == StFault);
        fault_code  = fault_code_q;
        irr_ticks   = irr_q;
        vent_ticks  = vent_q;
    end

endmodule

// File: tb/tb_irrigation_cycle_scheduler.sv
// Directed bench for irrigation_cycle_scheduler with a simple sequencer stub.
module tb_irrigation_cycle_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_d1 = 8'd0, cfg_d2 = 8'd0, cfg_d3 = 8'd0, cfg_rest = 8'd0;
    logic [3:0]  cfg_repeat = 4'd0;
    logic        seq_done, seq_irrigation, seq_ventilation;
    logic        seq_enable, busy, sched_done, fault;
    logic [7:0]  seq_d1, seq_d2, seq_d3;
    logic [3:0]  cycles_done;
    logic [1:0]  fault_code;
    logic [15:0] irr_ticks, vent_ticks;

    int tests = 0;
    int fails = 0;

    // Sequencer stub controls
    logic stub_hang = 1'b0;
    logic force_ovl = 1'b0;
    int   stub_extra = 0;
    int   cnt = 0;

    // Monitor accumulators (written only by the monitor)
    int   en_hi_total = 0;
    int   sd_total = 0;
    int   rise_total = 0;
    int   low_len = 0;
    logic en_prev = 1'b0;
    int   gaps [0:15];

    int   r0, h0, s0;

    always #5 clk = ~clk;

    irrigation_cycle_scheduler #(.MARGIN(4), .TICK_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_d1          (cfg_d1),
        .cfg_d2          (cfg_d2),
        .cfg_d3          (cfg_d3),
        .cfg_rest        (cfg_rest),
        .cfg_repeat      (cfg_repeat),
        .seq_done        (seq_done),
        .seq_irrigation  (seq_irrigation),
        .seq_ventilation (seq_ventilation),
        .seq_enable      (seq_enable),
        .seq_d1          (seq_d1),
        .seq_d2          (seq_d2),
        .seq_d3          (seq_d3),
        .busy            (busy),
        .cycles_done     (cycles_done),
        .sched_done      (sched_done),
        .fault           (fault),
        .fault_code      (fault_code),
        .irr_ticks       (irr_ticks),
        .vent_ticks      (vent_ticks)
    );

    // Stub: cnt = cycles since enable rose; stage1 irrigates, stage3 ventilates.
    always @(posedge clk) cnt <= seq_enable ? cnt + 1 : 0;

    assign seq_irrigation  = force_ovl | (seq_enable && cnt >= 1 && cnt <= int'(seq_d1));
    assign seq_ventilation = force_ovl | (seq_enable &&
                             cnt >= 1 + int'(seq_d1) + int'(seq_d2) &&
                             cnt <= int'(seq_d1) + int'(seq_d2) + int'(seq_d3));
    assign seq_done = seq_enable && !stub_hang &&
                      (cnt == int'(seq_d1) + int'(seq_d2) + int'(seq_d3) + stub_extra);

    initial for (int i = 0; i < 16; i++) gaps[i] = 0;

    always @(negedge clk) begin
        en_hi_total <= en_hi_total + (seq_enable ? 1 : 0);
        sd_total    <= sd_total + (sched_done ? 1 : 0);
        en_prev     <= seq_enable;
        if (seq_enable && !en_prev) begin
            gaps[rise_total % 16] <= low_len;
            rise_total <= rise_total + 1;
            low_len    <= 0;
        end else if (!seq_enable) begin
            low_len <= low_len + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int a, input int b, input int c, input int r, input int rep);
        cfg_d1     = 8'(a);
        cfg_d2     = 8'(b);
        cfg_d3     = 8'(c);
        cfg_rest   = 8'(r);
        cfg_repeat = 4'(rep);
    endtask

    task automatic snap();
        r0 = rise_total;
        h0 = en_hi_total;
        s0 = sd_total;
    endtask

    task automatic clear_fault();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_enable", 32'(seq_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_d1", 32'(seq_d1), 32'd0);
        reset = 1'b0;
        tick(2);

        // T1: d=2/3/4, rest 0, repeat 1
        set_cfg(2, 3, 4, 0, 1);
        snap();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t1_enable_up", 32'(seq_enable), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_seq_d1", 32'(seq_d1), 32'd2);
        check("t1_seq_d2", 32'(seq_d2), 32'd3);
        check("t1_seq_d3", 32'(seq_d3), 32'd4);
        set_cfg(9, 9, 9, 9, 9); // ignored while busy
        tick(9);
        check("t1_enable_last", 32'(seq_enable), 32'd1);
        tick(1);
        check("t1_release_en", 32'(seq_enable), 32'd0);
        check("t1_release_busy", 32'(busy), 32'd1);
        check("t1_cycles", 32'(cycles_done), 32'd1);
        tick(1);
        check("t1_sched_done", 32'(sched_done), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_irr", 32'(irr_ticks), 32'd2);
        check("t1_vent", 32'(vent_ticks), 32'd4);
        check("t1_shadow_kept", 32'(seq_d1), 32'd2);
        tick(1);
        check("t1_sched_pulse", 32'(sched_done), 32'd0);
        check("t1_en_cycles", 32'(en_hi_total - h0), 32'd10);
        check("t1_sd_count", 32'(sd_total - s0), 32'd1);

        // T2: d=1/1/1, rest 5, repeat 3
        set_cfg(1, 1, 1, 5, 3);
        snap();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick(1);
        check("t2_finished", 32'(busy), 32'd0);
        check("t2_sched_done", 32'(sched_done), 32'd1);
        check("t2_cycles", 32'(cycles_done), 32'd3);
        check("t2_runs", 32'(rise_total - r0), 32'd3);
        check("t2_en_cycles", 32'(en_hi_total - h0), 32'd12);
        check("t2_gap1", 32'(gaps[(r0 + 1) % 16]), 32'd6);
        check("t2_gap2", 32'(gaps[(r0 + 2) % 16]), 32'd6);
        tick(2);
        check("t2_sd_count", 32'(sd_total - s0), 32'd1);

        // T3: zero duration -> CFG fault, shadows unchanged
        set_cfg(3, 0, 3, 0, 1);
        snap();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t3_fault", 32'(fault), 32'd1);
        check("t3_code", 32'(fault_code), 32'd1);
        check("t3_shadow", 32'(seq_d2), 32'd1);
        tick(3);
        check("t3_no_enable", 32'(en_hi_total - h0), 32'd0);
        check("t3_sticky", 32'(fault_code), 32'd1);
        clear_fault();
        check("t3_cleared", 32'(fault), 32'd0);
        check("t3_code_clr", 32'(fault_code), 32'd0);
        check("t3_no_launch", 32'(busy), 32'd0);

        // T4: hung sequencer -> TIMEOUT after 10 RUN cycles
        set_cfg(2, 2, 2, 0, 1);
        stub_hang = 1'b1;
        snap();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        check("t4_still_run", 32'(seq_enable), 32'd1);
        check("t4_no_fault_yet", 32'(fault), 32'd0);
        tick(1);
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_code", 32'(fault_code), 32'd2);
        check("t4_enable_drop", 32'(seq_enable), 32'd0);
        check("t4_en_cycles", 32'(en_hi_total - h0), 32'd10);
        stub_hang = 1'b0;
        clear_fault();

        // T4b: done arriving in the budget cycle wins over the watchdog
        stub_extra = 3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        check("t4b_no_fault", 32'(fault), 32'd0);
        check("t4b_cycles", 32'(cycles_done), 32'd1);
        tick(1);
        check("t4b_sched_done", 32'(sched_done), 32'd1);
        stub_extra = 0;
        tick(1);

        // T5: overlap mid-RUN -> PROTO
        set_cfg(2, 3, 4, 0, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        force_ovl = 1'b1;
        tick(1);
        force_ovl = 1'b0;
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_code", 32'(fault_code), 32'd3);
        check("t5_enable", 32'(seq_enable), 32'd0);
        clear_fault();

        // T6: repeat 0, abort together with 2nd seq_done
        set_cfg(1, 1, 1, 2, 0);
        snap();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        check("t6_done_seen", 32'(seq_done), 32'd1);
        check("t6_cycles_pre", 32'(cycles_done), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_enable", 32'(seq_enable), 32'd0);
        check("t6_cycles", 32'(cycles_done), 32'd1);
        check("t6_no_sched", 32'(sched_done), 32'd0);
        tick(2);
        check("t6_sd_count", 32'(sd_total - s0), 32'd0);

        // T7: async reset mid-REST clears outputs without a clock edge
        set_cfg(1, 1, 1, 5, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        check("t7_in_rest", 32'(busy), 32'd1);
        check("t7_rest_en", 32'(seq_enable), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_cycles", 32'(cycles_done), 32'd0);
        check("t7_d1", 32'(seq_d1), 32'd0);
        check("t7_irr", 32'(irr_ticks), 32'd0);
        check("t7_enable", 32'(seq_enable), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
